// File: rtl/milano_pkg.sv
// Shared decode types and encodings for the milano RV32 front end.
package milano_pkg;

  typedef enum logic [4:0] {
    ALU_NONE   = 5'd0,
    ALU_ADD    = 5'd1,
    ALU_SUB    = 5'd2,
    ALU_XOR    = 5'd3,
    ALU_OR     = 5'd4,
    ALU_AND    = 5'd5,
    ALU_SLL    = 5'd6,
    ALU_SRL    = 5'd7,
    ALU_SRA    = 5'd8,
    ALU_SLT    = 5'd9,
    ALU_SLTU   = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_opt_e;

  typedef enum logic [6:0] {
    OPCODE_OP     = 7'b0110011,
    OPCODE_OP_IMM = 7'b0010011,
    OPCODE_LUI    = 7'b0110111,
    OPCODE_AUIPC  = 7'b0010111
  } opcode_e;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Contents of the ID/EX pipeline register (valid is kept alongside).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op_a;
    logic [31:0] op_b;
    alu_opt_e    alu_op;
    logic [4:0]  rd_addr;
    logic        rd_wr_en;
    logic        illegal;
  } id_ex_t;

  // ALU_NONE encodes as zero, so an all-zero entry is the idle entry.
  localparam id_ex_t ID_EX_RESET = '0;

  // Register-register base operations; funct7 only splits ADD/SUB and SRL/SRA.
  function automatic alu_opt_e base_alu(input logic [2:0] funct3);
    case (funct3)
      F3_ADD_SUB: base_alu = ALU_ADD;
      F3_SLL:     base_alu = ALU_SLL;
      F3_SLT:     base_alu = ALU_SLT;
      F3_SLTU:    base_alu = ALU_SLTU;
      F3_XOR:     base_alu = ALU_XOR;
      F3_SRL_SRA: base_alu = ALU_SRL;
      F3_OR:      base_alu = ALU_OR;
      default:    base_alu = ALU_AND;
    endcase
  endfunction

  // M-extension operations, all under funct7 = 0000001.
  function automatic alu_opt_e muldiv_alu(input logic [2:0] funct3);
    case (funct3)
      3'b000:  muldiv_alu = ALU_MUL;
      3'b001:  muldiv_alu = ALU_MULH;
      3'b010:  muldiv_alu = ALU_MULHSU;
      3'b011:  muldiv_alu = ALU_MULHU;
      3'b100:  muldiv_alu = ALU_DIV;
      3'b101:  muldiv_alu = ALU_DIVU;
      3'b110:  muldiv_alu = ALU_REM;
      default: muldiv_alu = ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate extraction: I-type, U-type or zero-extended shift amount by opcode.
module imm_gen
  import milano_pkg::*;
(
  input  opcode_e      opcode_i,
  input  logic [31:12] instr_hi_i,
  output logic [31:0]  imm_o
);

  logic [2:0] w_funct3;
  assign w_funct3 = instr_hi_i[14:12];

  // Select the immediate format implied by the opcode; zero otherwise.
  always_comb begin
    imm_o = '0;
    case (opcode_i)
      OPCODE_OP_IMM: begin
        if (w_funct3 == F3_SLL || w_funct3 == F3_SRL_SRA) begin
          imm_o = {27'b0, instr_hi_i[24:20]};
        end else begin
          imm_o = {{20{instr_hi_i[31]}}, instr_hi_i[31:20]};
        end
      end
      OPCODE_LUI, OPCODE_AUIPC: imm_o = {instr_hi_i[31:12], 12'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I(+M) decode stage: decode, immediate generation, illegal
// flagging, one ID/EX register with valid/ready, flush and a legal-accept counter.
module decode_stage
  import milano_pkg::*;
#(
  parameter bit          RV32M = 1'b0,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [31:0]      instr_rdata_i,
  input  logic [31:0]      instr_addr_i,
  output logic [4:0]       rs1_addr_o,
  output logic [4:0]       rs2_addr_o,
  input  logic [31:0]      rs1_rdata_i,
  input  logic [31:0]      rs2_rdata_i,
  output logic             ex_valid_o,
  input  logic             ex_ready_i,
  output logic [31:0]      ex_pc_o,
  output logic [31:0]      ex_op_a_o,
  output logic [31:0]      ex_op_b_o,
  output alu_opt_e         ex_alu_op_o,
  output logic [4:0]       ex_rd_addr_o,
  output logic             ex_rd_wr_en_o,
  output logic             ex_illegal_o,
  output logic [CNT_W-1:0] decoded_cnt_o
);

  opcode_e     w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;
  logic        w_legal;
  alu_opt_e    w_alu;
  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  id_ex_t      w_dec_p0;
  logic        w_accept;

  id_ex_t          r_ex_p1;
  logic            r_vld_p1;
  logic [CNT_W-1:0] r_cnt;

  assign w_opcode = opcode_e'(instr_rdata_i[6:0]);
  assign w_rd     = instr_rdata_i[11:7];
  assign w_funct3 = instr_rdata_i[14:12];
  assign w_funct7 = instr_rdata_i[31:25];

  assign rs1_addr_o = instr_rdata_i[19:15];
  assign rs2_addr_o = instr_rdata_i[24:20];

  assign instr_ready_o = !r_vld_p1 || ex_ready_i;
  assign w_accept      = instr_valid_i && instr_ready_o && !flush_i;

  imm_gen u_imm_gen (
    .opcode_i   (w_opcode),
    .instr_hi_i (instr_rdata_i[31:12]),
    .imm_o      (w_imm)
  );

  // Classify the instruction and pick the ALU operation and operands.
  always_comb begin
    w_legal = 1'b0;
    w_alu   = ALU_NONE;
    w_op_a  = '0;
    w_op_b  = '0;
    case (w_opcode)
      OPCODE_OP: begin
        w_op_a = rs1_rdata_i;
        w_op_b = rs2_rdata_i;
        if (w_funct7 == F7_BASE) begin
          w_legal = 1'b1;
          w_alu   = base_alu(w_funct3);
        end else if (w_funct7 == F7_ALT) begin
          if (w_funct3 == F3_ADD_SUB) begin
            w_legal = 1'b1;
            w_alu   = ALU_SUB;
          end else if (w_funct3 == F3_SRL_SRA) begin
            w_legal = 1'b1;
            w_alu   = ALU_SRA;
          end
        end else if (w_funct7 == F7_MULDIV && RV32M) begin
          w_legal = 1'b1;
          w_alu   = muldiv_alu(w_funct3);
        end
      end
      OPCODE_OP_IMM: begin
        w_op_a = rs1_rdata_i;
        w_op_b = w_imm;
        if (w_funct3 == F3_SLL) begin
          // Only SLLI with a clean upper field exists.
          w_legal = (w_funct7 == F7_BASE);
          w_alu   = ALU_SLL;
        end else if (w_funct3 == F3_SRL_SRA) begin
          w_legal = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
          w_alu   = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
        end else begin
          // instr[31:25] belongs to the immediate here, so funct7 is ignored.
          w_legal = 1'b1;
          w_alu   = base_alu(w_funct3);
        end
      end
      OPCODE_LUI: begin
        w_legal = 1'b1;
        w_alu   = ALU_ADD;
        w_op_a  = '0;
        w_op_b  = w_imm;
      end
      OPCODE_AUIPC: begin
        w_legal = 1'b1;
        w_alu   = ALU_ADD;
        w_op_a  = instr_addr_i;
        w_op_b  = w_imm;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Assemble the ID/EX entry; illegal instructions carry zero operands and no write.
  always_comb begin
    w_dec_p0    = ID_EX_RESET;
    w_dec_p0.pc = instr_addr_i;
    if (w_legal) begin
      w_dec_p0.op_a     = w_op_a;
      w_dec_p0.op_b     = w_op_b;
      w_dec_p0.alu_op   = w_alu;
      w_dec_p0.rd_addr  = w_rd;
      w_dec_p0.rd_wr_en = (w_rd != 5'd0);
    end else begin
      w_dec_p0.illegal  = 1'b1;
    end
  end

  // ---- ID/EX boundary ----
  // Load on accept, drain when consumed or flushed, otherwise hold for a stalled EX.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p1 <= 1'b0;
      r_ex_p1  <= ID_EX_RESET;
    end else if (w_accept) begin
      r_vld_p1 <= 1'b1;
      r_ex_p1  <= w_dec_p0;
    end else if (ex_ready_i || flush_i) begin
      r_vld_p1 <= 1'b0;
      r_ex_p1  <= ID_EX_RESET;
    end
  end

  // Count accepted legal instructions, sticking at the maximum value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_accept && !w_dec_p0.illegal && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ex_valid_o    = r_vld_p1;
  assign ex_pc_o       = r_ex_p1.pc;
  assign ex_op_a_o     = r_ex_p1.op_a;
  assign ex_op_b_o     = r_ex_p1.op_b;
  assign ex_alu_op_o   = r_ex_p1.alu_op;
  assign ex_rd_addr_o  = r_ex_p1.rd_addr;
  assign ex_rd_wr_en_o = r_ex_p1.rd_wr_en;
  assign ex_illegal_o  = r_ex_p1.illegal;
  assign decoded_cnt_o = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (RV32M=1/CNT_W=16 and RV32M=0/CNT_W=2)
// share one stimulus stream and are compared to an instruction-level model.
module tb_decode_stage;
  import milano_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, instr_valid, ex_ready;
  logic [31:0] instr, pc, rs1_d, rs2_d;

  logic        rdy_a, vld_a, we_a, ill_a;
  logic [4:0]  ra1_a, ra2_a, rd_a;
  logic [31:0] pc_a, opa_a, opb_a;
  alu_opt_e    alu_a;
  logic [15:0] cnt_a;

  logic        rdy_b, vld_b, we_b, ill_b;
  logic [4:0]  ra1_b, ra2_b, rd_b;
  logic [31:0] pc_b, opa_b, opb_b;
  alu_opt_e    alu_b;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc, a, b;
    alu_opt_e    op;
    logic [4:0]  rd;
    logic        we, ill;
  } exp_t;

  logic e_vld;
  exp_t e_m, e_i;
  int   c_m, c_i;
  bit   just_reset;

  always #5 clk = ~clk;

  decode_stage #(.RV32M(1'b1), .CNT_W(16)) dut_m (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_valid_i(instr_valid),
    .instr_ready_o(rdy_a), .instr_rdata_i(instr), .instr_addr_i(pc),
    .rs1_addr_o(ra1_a), .rs2_addr_o(ra2_a), .rs1_rdata_i(rs1_d), .rs2_rdata_i(rs2_d),
    .ex_valid_o(vld_a), .ex_ready_i(ex_ready), .ex_pc_o(pc_a), .ex_op_a_o(opa_a),
    .ex_op_b_o(opb_a), .ex_alu_op_o(alu_a), .ex_rd_addr_o(rd_a),
    .ex_rd_wr_en_o(we_a), .ex_illegal_o(ill_a), .decoded_cnt_o(cnt_a));

  decode_stage #(.RV32M(1'b0), .CNT_W(2)) dut_i (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_valid_i(instr_valid),
    .instr_ready_o(rdy_b), .instr_rdata_i(instr), .instr_addr_i(pc),
    .rs1_addr_o(ra1_b), .rs2_addr_o(ra2_b), .rs1_rdata_i(rs1_d), .rs2_rdata_i(rs2_d),
    .ex_valid_o(vld_b), .ex_ready_i(ex_ready), .ex_pc_o(pc_b), .ex_op_a_o(opa_b),
    .ex_op_b_o(opb_b), .ex_alu_op_o(alu_b), .ex_rd_addr_o(rd_b),
    .ex_rd_wr_en_o(we_b), .ex_illegal_o(ill_b), .decoded_cnt_o(cnt_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // What the ISA says each instruction word means.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] ipc,
                                 input logic [31:0] r1, input logic [31:0] r2, input bit m);
    exp_t       e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    bit         ok;
    alu_opt_e   rr [8];
    alu_opt_e   mm [8];
    rr = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    mm = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    e = '0; e.pc = ipc; ok = 0;
    if (opc == 7'h33) begin
      e.a = r1; e.b = r2;
      if (f7 == 7'h00) begin ok = 1; e.op = rr[f3]; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1; e.op = ALU_SUB; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; e.op = ALU_SRA; end
      else if (f7 == 7'h01 && m) begin ok = 1; e.op = mm[f3]; end
    end else if (opc == 7'h13) begin
      e.a = r1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        e.b = 32'(ins[24:20]);
        if (f7 == 7'h00) begin ok = 1; e.op = (f3 == 3'd1) ? ALU_SLL : ALU_SRL; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; e.op = ALU_SRA; end
      end else begin
        ok = 1; e.op = rr[f3];
        e.b = 32'($signed(ins[31:20]));
      end
    end else if (opc == 7'h37) begin
      ok = 1; e.op = ALU_ADD; e.a = 0; e.b = ins & 32'hFFFFF000;
    end else if (opc == 7'h17) begin
      ok = 1; e.op = ALU_ADD; e.a = ipc; e.b = ins & 32'hFFFFF000;
    end
    if (ok) begin
      e.rd = ins[11:7];
      e.we = (ins[11:7] != 0);
    end else begin
      e.a = 0; e.b = 0; e.op = ALU_NONE; e.we = 0; e.ill = 1;
    end
    return e;
  endfunction

  task automatic chk_dut(input string n, input logic v, input logic [31:0] p, a, b,
                         input alu_opt_e op, input logic [4:0] rd, input logic we, ill,
                         input logic [31:0] cnt, input exp_t e, input int c);
    chk({n, ".valid"}, 32'(v), 32'(e_vld));
    chk({n, ".cnt"}, cnt, 32'(c));
    if (e_vld || just_reset) begin
      chk({n, ".pc"}, p, e.pc);
      chk({n, ".op_a"}, a, e.a);
      chk({n, ".op_b"}, b, e.b);
      chk({n, ".alu"}, 32'(op), 32'(e.op));
      chk({n, ".wr_en"}, 32'(we), 32'(e.we));
      chk({n, ".illegal"}, 32'(ill), 32'(e.ill));
      if (!e.ill) chk({n, ".rd"}, 32'(rd), 32'(e.rd));
    end
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check register.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] ipc,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic rdy, input logic fl, input logic rs);
    logic acc;
    exp_t dm, di;
    @(negedge clk);
    instr_valid = v; instr = ins; pc = ipc; rs1_d = r1; rs2_d = r2;
    ex_ready = rdy; flush = fl; rst = rs;
    #1;
    chk("m.instr_ready", 32'(rdy_a), 32'(!e_vld || rdy));
    chk("i.instr_ready", 32'(rdy_b), 32'(!e_vld || rdy));
    chk("rs1_addr", 32'(ra1_a), 32'(ins[19:15]));
    chk("rs2_addr", 32'(ra2_b), 32'(ins[24:20]));
    acc = v && (!e_vld || rdy) && !fl;
    dm = model(ins, ipc, r1, r2, 1'b1);
    di = model(ins, ipc, r1, r2, 1'b0);
    @(posedge clk);
    just_reset = rs;
    if (rs) begin
      e_vld = 0; e_m = '0; e_i = '0; c_m = 0; c_i = 0;
    end else if (acc) begin
      e_vld = 1; e_m = dm; e_i = di;
      if (!dm.ill && c_m < 65535) c_m++;
      if (!di.ill && c_i < 3) c_i++;
    end else if (rdy || fl) begin
      e_vld = 0;
    end
    #1;
    chk_dut("m", vld_a, pc_a, opa_a, opb_a, alu_a, rd_a, we_a, ill_a, 32'(cnt_a), e_m, c_m);
    chk_dut("i", vld_b, pc_b, opa_b, opb_b, alu_b, rd_b, we_b, ill_b, 32'(cnt_b), e_i, c_i);
  endtask

  initial begin
    logic [31:0] ri;
    logic [6:0]  opcs [5];
    logic [6:0]  f7s  [4];
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03};
    f7s  = '{7'h00, 7'h20, 7'h01, 7'h7f};
    rst = 1; flush = 0; instr_valid = 0; ex_ready = 0;
    instr = 0; pc = 0; rs1_d = 0; rs2_d = 0;
    e_vld = 0; e_m = '0; e_i = '0; c_m = 0; c_i = 0; just_reset = 1;
    repeat (2) @(posedge clk);

    step(0, 32'h0, 0, 0, 0, 0, 0, 1);                              // reset state
    step(1, 32'h00500093, 32'h0, 0, 0, 1, 0, 0);                   // ADDI x1,x0,5
    step(1, 32'h402081B3, 32'h4, 10, 3, 1, 0, 0);                  // SUB x3,x1,x2
    repeat (3) step(1, 32'h002081B3, 32'h8, 7, 9, 0, 0, 0);        // stall, hold SUB
    step(1, 32'h002081B3, 32'h8, 7, 9, 1, 0, 0);                   // ADD accepted
    step(1, 32'h123452B7, 32'hC, 1, 2, 1, 0, 0);                   // LUI
    step(1, 32'h00001317, 32'h80, 1, 2, 1, 0, 0);                  // AUIPC
    step(1, 32'h022081B3, 32'h84, 6, 7, 1, 0, 0);                  // MUL
    step(1, 32'h4030D093, 32'h88, 32'hF0, 0, 1, 0, 0);             // SRAI
    step(1, 32'h40309093, 32'h8C, 5, 0, 1, 0, 0);                  // bad SLLI
    step(1, 32'h00000013, 32'h90, 0, 0, 1, 0, 0);                  // NOP
    step(1, 32'h00500093, 32'h94, 0, 0, 0, 0, 0);                  // load, EX stalled
    step(1, 32'h002081B3, 32'h98, 1, 1, 0, 1, 0);                  // flush drops both
    step(0, 32'h0, 32'h9C, 0, 0, 1, 0, 0);
    step(1, 32'h00500093, 32'hA0, 0, 0, 0, 0, 0);                  // load, stall
    step(0, 32'h0, 32'hA4, 0, 0, 0, 0, 0);
    step(1, 32'h002081B3, 32'hA8, 1, 1, 0, 0, 1);                  // reset mid-stall
    repeat (5) step(1, 32'h00500093, 32'hB0, 0, 0, 1, 0, 0);       // counter saturation
    step(0, 32'h0, 32'hC0, 0, 0, 1, 0, 0);

    for (int n = 0; n < 400; n++) begin
      ri = $urandom;
      ri[6:0] = opcs[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) != 0) ri[31:25] = f7s[$urandom_range(0, 3)];
      step($urandom_range(0, 3) != 0, ri, $urandom, $urandom, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 60) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
